decoder_seq: RTL and testbench
==============================

# decoder_seq

Parametrised multi-cycle instruction decoder and control sequencer for the 8-bit CPU, successor to the single-phase decoder. It owns the FETCH/DECODE/EXECUTE cycle, samples ALU flags, drives datapath selects and write enables, and adds ADC, OR, XOR, STORE with a memory-ready handshake and timeout, HALT, and illegal-opcode detection. It sits between the instruction register/flag outputs of the datapath and all datapath enables.

## Interface
- IW, 8: instruction width; opcode = IR[IW-1:IW-4]; IW ≥ 8.
- MEM_TIMEOUT, 8: max MEM cycles waiting for ip_mem_ready (1..255).

- clock  in  1  system clock, rising edge.
- ip_clear  in  1  reset, synchronous, active-high.
- ip_clock_enable  in  1  0 = freeze sequencer.
- ip_IR  in  IW  instruction word from memory.
- ip_zero, ip_carry  in  1 each  ALU flags.
- ip_mem_ready  in  1  RAM write accepted.
- op_en_in  out  1  load IR / instruction fetch.
- op_alu_sel  out  5  ALU function.
- op_alu_cin  out  1  ALU carry-in (ADC).
- op_mux_a  out  1  1 = ALU B from input port.
- op_mux_b  out  1  1 = immediate operand, 0 = RAM.
- op_en_da  out  1  write accumulator.
- op_en_out  out  1  write output port.
- op_en_pc  out  1  load PC from operand (jump taken).
- op_pc_inc  out  1  PC increment.
- op_RAM_we  out  1  RAM write enable.
- op_halted  out  1  in HALT.
- op_illegal  out  1  one-cycle pulse: reserved opcode.
- op_fault  out  1  one-cycle pulse: STORE timeout.
- op_state  out  3  state code (debug).

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4. op_state = encoding.
- FETCH: op_en_in=1; latch ip_IR into internal IR → DECODE.
- DECODE: sample ip_zero/ip_carry into flag regs; no enables. Opcode 1111 → HALT; else → EXEC.
- EXEC (one cycle) per opcode, then → FETCH (STORE → MEM):
  - 0000 LOAD, 0001 AND, 0010 OR, 0011 XOR, 0100 ADD, 0101 ADC, 0110 SUB: op_alu_sel={1'b0,opcode}, op_mux_b=IR[IW-5], op_en_da=1, op_pc_inc=1; ADC: op_alu_cin=carry flag reg.
  - 0111 STORE: op_RAM_we=1, op_pc_inc=1.
  - 1000 JUMP: op_en_pc=1.
  - 1001 JUMPcc: flag = IR[IW-5] ? carry : zero; taken = flag XOR IR[IW-6]; taken → op_en_pc=1, else op_pc_inc=1.
  - 1010 INPUT: op_mux_a=1, op_alu_sel=0, op_en_da=1, op_pc_inc=1.
  - 1011 NOP: op_pc_inc=1.
  - 1110 OUTPUT: op_en_out=1, op_pc_inc=1.
  - 1100, 1101: op_illegal=1, op_pc_inc=1 (skip).
- MEM: op_RAM_we held 1; timeout counter counts cycles in MEM. ip_mem_ready=1 → FETCH. Counter reaches MEM_TIMEOUT without ready → op_fault pulse, op_RAM_we=0 that cycle, → FETCH.
- HALT: op_halted=1, all enables 0; exits only via ip_clear.
- Outputs combinational from state, internal IR and flag regs; unlisted outputs 0.

## Timing
- Reset: ip_clear sampled high → next edge state=FETCH, IR=0, flags=0, counter=0. While ip_clear high all outputs forced 0 (op_state reads 0). Reset mid-STORE aborts write immediately.
- ip_clock_enable=0: state, IR, flags, counter hold; every enable (op_en_*, op_pc_inc, op_RAM_we, op_illegal, op_fault) forced 0; op_state/op_halted unaffected. ip_clear overrides enable.
- Latency: non-STORE instructions 3 cycles; STORE 4 to 3+MEM_TIMEOUT cycles; HALT reached 2 cycles after FETCH.
- ip_mem_ready sampled only in MEM; ready on the timeout cycle counts as success (no fault).
- Flags sampled at DECODE→EXEC edge only; later flag changes do not affect that instruction.
- Counter cleared on every MEM entry.

## Test plan
- Reset: ip_clear=1 for 2 cycles with IR=8'hF0 → all outputs 0, then FETCH, op_en_in=1 one cycle after release.
- ALU sweep: IR 0x00..0x60 step 0x10, IR[3]=1 for ADD → op_alu_sel=opcode, op_en_da/op_pc_inc=1 in EXEC only, op_mux_b=1 for ADD; ADC with carry=1 → op_alu_cin=1.
- Jumps: zero=1,carry=0; IR 0x90/0x94/0x98/0x9C → op_en_pc 1/0/0/1, op_pc_inc complement.
- STORE handshake: IR=0x70, ready after 3 MEM cycles → op_RAM_we 4 cycles, no fault; ready never → op_fault after 8 MEM cycles, back to FETCH.
- Stall: drop ip_clock_enable for 5 cycles during EXEC of ADD → enables 0, state 2 held, op_en_da asserts once after release.
- Illegal/HALT: IR=0xC0 → op_illegal pulse, FETCH; IR=0xF0 → op_halted stays 1 for 20 cycles until ip_clear.

Source files
------------

// File: rtl/decoder_seq_if.sv
// rtl/decoder_seq_if.sv - datapath-side signal bundle between the datapath and decoder_seq
interface decoder_seq_if #(
    parameter int IW = 8
);
    logic          ip_clock_enable;
    logic [IW-1:0] ip_IR;
    logic          ip_zero;
    logic          ip_carry;
    logic          ip_mem_ready;

    logic          op_en_in;
    logic [4:0]    op_alu_sel;
    logic          op_alu_cin;
    logic          op_mux_a;
    logic          op_mux_b;
    logic          op_en_da;
    logic          op_en_out;
    logic          op_en_pc;
    logic          op_pc_inc;
    logic          op_RAM_we;
    logic          op_halted;
    logic          op_illegal;
    logic          op_fault;
    logic [2:0]    op_state;

    modport master (
        output ip_clock_enable, ip_IR, ip_zero, ip_carry, ip_mem_ready,
        input  op_en_in, op_alu_sel, op_alu_cin, op_mux_a, op_mux_b, op_en_da,
               op_en_out, op_en_pc, op_pc_inc, op_RAM_we, op_halted, op_illegal,
               op_fault, op_state
    );

    modport slave (
        input  ip_clock_enable, ip_IR, ip_zero, ip_carry, ip_mem_ready,
        output op_en_in, op_alu_sel, op_alu_cin, op_mux_a, op_mux_b, op_en_da,
               op_en_out, op_en_pc, op_pc_inc, op_RAM_we, op_halted, op_illegal,
               op_fault, op_state
    );
endinterface

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - FETCH/DECODE/EXEC/MEM/HALT instruction sequencer for the 8-bit CPU
module decoder_seq #(
    parameter int IW          = 8,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic         clock,
    input  logic         ip_clear,
    decoder_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    // Only the opcode and the two modifier bits below it are ever consulted.
    logic [5:0] r_ir;
    logic       r_zero;
    logic       r_carry;
    logic [7:0] r_mem_cnt;

    logic [3:0] w_opcode;
    logic       w_taken;
    logic       w_timeout;
    logic       w_en_in;
    logic [4:0] w_alu_sel;
    logic       w_alu_cin;
    logic       w_mux_a;
    logic       w_mux_b;
    logic       w_en_da;
    logic       w_en_out;
    logic       w_en_pc;
    logic       w_pc_inc;
    logic       w_ram_we;
    logic       w_illegal;
    logic       w_fault;

    assign w_opcode  = r_ir[5:2];
    assign w_taken   = (r_ir[1] ? r_carry : r_zero) ^ r_ir[0];
    assign w_timeout = (r_mem_cnt == 8'(MEM_TIMEOUT - 1)) && !bus.ip_mem_ready;

    always_ff @(posedge clock) begin
        if (ip_clear) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_mem_cnt <= '0;
        end else if (bus.ip_clock_enable) begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_ir <= bus.ip_IR[IW-1:IW-6];
            end
            if (r_state == S_DECODE) begin
                r_zero  <= bus.ip_zero;
                r_carry <= bus.ip_carry;
            end
            // Zero outside MEM, so every MEM entry starts counting from 0.
            r_mem_cnt <= (r_state == S_MEM) ? r_mem_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_en_in   = 1'b0;
        w_alu_sel = 5'd0;
        w_alu_cin = 1'b0;
        w_mux_a   = 1'b0;
        w_mux_b   = 1'b0;
        w_en_da   = 1'b0;
        w_en_out  = 1'b0;
        w_en_pc   = 1'b0;
        w_pc_inc  = 1'b0;
        w_ram_we  = 1'b0;
        w_illegal = 1'b0;
        w_fault   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_en_in = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                w_next = (w_opcode == 4'hF) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                        w_alu_sel = {1'b0, w_opcode};
                        w_mux_b   = r_ir[1];
                        w_en_da   = 1'b1;
                        w_pc_inc  = 1'b1;
                        w_alu_cin = (w_opcode == 4'h5) && r_carry;
                    end
                    4'h7: begin
                        w_ram_we = 1'b1;
                        w_pc_inc = 1'b1;
                        w_next   = S_MEM;
                    end
                    4'h8: w_en_pc = 1'b1;
                    4'h9: begin
                        w_en_pc  = w_taken;
                        w_pc_inc = !w_taken;
                    end
                    4'hA: begin
                        w_mux_a  = 1'b1;
                        w_en_da  = 1'b1;
                        w_pc_inc = 1'b1;
                    end
                    4'hB: w_pc_inc = 1'b1;
                    4'hE: begin
                        w_en_out = 1'b1;
                        w_pc_inc = 1'b1;
                    end
                    4'hC, 4'hD: begin
                        w_illegal = 1'b1;
                        w_pc_inc  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Ready on the last allowed cycle still wins over the timeout.
                w_ram_we = !w_timeout;
                w_fault  = w_timeout;
                if (bus.ip_mem_ready || w_timeout) begin
                    w_next = S_FETCH;
                end
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.op_en_in   = 1'b0;
        bus.op_alu_sel = 5'd0;
        bus.op_alu_cin = 1'b0;
        bus.op_mux_a   = 1'b0;
        bus.op_mux_b   = 1'b0;
        bus.op_en_da   = 1'b0;
        bus.op_en_out  = 1'b0;
        bus.op_en_pc   = 1'b0;
        bus.op_pc_inc  = 1'b0;
        bus.op_RAM_we  = 1'b0;
        bus.op_halted  = 1'b0;
        bus.op_illegal = 1'b0;
        bus.op_fault   = 1'b0;
        bus.op_state   = 3'd0;
        if (!ip_clear) begin
            bus.op_state   = r_state;
            bus.op_halted  = (r_state == S_HALT);
            bus.op_alu_sel = w_alu_sel;
            bus.op_alu_cin = w_alu_cin;
            bus.op_mux_a   = w_mux_a;
            bus.op_mux_b   = w_mux_b;
            if (bus.ip_clock_enable) begin
                bus.op_en_in   = w_en_in;
                bus.op_en_da   = w_en_da;
                bus.op_en_out  = w_en_out;
                bus.op_en_pc   = w_en_pc;
                bus.op_pc_inc  = w_pc_inc;
                bus.op_RAM_we  = w_ram_we;
                bus.op_illegal = w_illegal;
                bus.op_fault   = w_fault;
            end
        end
    end
endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - randomized scoreboard bench for decoder_seq
module tb_decoder_seq;
    localparam int TMO = 8;
    // Bit layout of the packed output vector compared each cycle.
    localparam int B_HALT = 16, B_ILL = 15, B_FAULT = 14, B_WE = 13, B_PCINC = 12;
    localparam int B_ENPC = 11, B_ENOUT = 10, B_ENDA = 9, B_MUXB = 8, B_MUXA = 7;
    localparam int B_CIN = 6, B_ENIN = 0;
    localparam logic [19:0] EN_MASK = 20'h0FE01;

    typedef struct {
        logic [19:0] vec;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        clock    = 1'b0;
    logic        ip_clear = 1'b1;
    logic [19:0] act;

    decoder_seq_if #(.IW(8)) bus();

    decoder_seq #(.IW(8), .MEM_TIMEOUT(TMO)) u_dut (
        .clock    (clock),
        .ip_clear (ip_clear),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    assign act = {bus.op_state, bus.op_halted, bus.op_illegal, bus.op_fault, bus.op_RAM_we,
                  bus.op_pc_inc, bus.op_en_pc, bus.op_en_out, bus.op_en_da, bus.op_mux_b,
                  bus.op_mux_a, bus.op_alu_cin, bus.op_alu_sel, bus.op_en_in};

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (act !== mon_e.vec) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", mon_e.tag, act, mon_e.vec);
            end
        end
    end

    function automatic logic [19:0] with_state(input int s);
        logic [19:0] v;
        v        = '0;
        v[19:17] = 3'(s);
        return v;
    endfunction

    // Expected EXEC-cycle outputs straight from the opcode table.
    function automatic logic [19:0] exec_exp(input logic [7:0] ir, input logic z, input logic c);
        logic [19:0] v;
        logic [3:0]  op;
        logic        taken;
        v  = with_state(2);
        op = ir[7:4];
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                v[5:1]    = {1'b0, op};
                v[B_MUXB] = ir[3];
                v[B_ENDA] = 1'b1;
                v[B_PCINC] = 1'b1;
                if (op == 4'h5) v[B_CIN] = c;
            end
            4'h7: begin
                v[B_WE]    = 1'b1;
                v[B_PCINC] = 1'b1;
            end
            4'h8: v[B_ENPC] = 1'b1;
            4'h9: begin
                taken      = (ir[3] ? c : z) ^ ir[2];
                v[B_ENPC]  = taken;
                v[B_PCINC] = ~taken;
            end
            4'hA: begin
                v[B_MUXA]  = 1'b1;
                v[B_ENDA]  = 1'b1;
                v[B_PCINC] = 1'b1;
            end
            4'hB: v[B_PCINC] = 1'b1;
            4'hE: begin
                v[B_ENOUT] = 1'b1;
                v[B_PCINC] = 1'b1;
            end
            4'hC, 4'hD: begin
                v[B_ILL]   = 1'b1;
                v[B_PCINC] = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic int rs(input bit en);
        if (en && ($urandom_range(0, 3) == 0)) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    task automatic step(input logic ce, input logic clr, input logic [7:0] ir, input logic z,
                        input logic c, input logic rdy, input logic [19:0] ev, input string tag);
        bus.ip_clock_enable = ce;
        ip_clear            = clr;
        bus.ip_IR           = ir;
        bus.ip_zero         = z;
        bus.ip_carry        = c;
        bus.ip_mem_ready    = rdy;
        exp_q.push_back('{vec: ev, tag: tag});
        @(posedge clock);
        #1;
    endtask

    task automatic phase(input logic [19:0] ev, input string tag, input logic [7:0] ir,
                         input logic z, input logic c, input logic rdy, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            step(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ev & ~EN_MASK, {tag, "_stall"});
        end
        step(1'b1, 1'b0, ir, z, c, rdy, ev, tag);
    endtask

    task automatic do_clear(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'($urandom), 1'b1, 8'hF0, 1'($urandom), 1'($urandom), 1'($urandom),
                 20'h0, "clear");
        end
    endtask

    // ready_at: MEM cycle (1-based) with ready high; 0 or >TMO never; negative clears in MEM.
    task automatic run_instr(input logic [7:0] ir, input logic z, input logic c,
                             input int ready_at, input int exec_stall, input bit rnd);
        logic [19:0] v;
        string       t;
        t       = $sformatf("ir%02h", ir);
        v       = with_state(0);
        v[B_ENIN] = 1'b1;
        phase(v, {t, "_fetch"}, ir, 1'($urandom), 1'($urandom), 1'($urandom), rs(rnd));
        phase(with_state(1), {t, "_decode"}, 8'($urandom), z, c, 1'($urandom), rs(rnd));
        if (ir[7:4] == 4'hF) return;
        phase(exec_exp(ir, z, c), {t, "_exec"}, 8'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), exec_stall + rs(rnd));
        if (ir[7:4] != 4'h7) return;
        for (int m = 1; m <= TMO; m++) begin
            if (ready_at < 0 && m == 2) begin
                do_clear(1);
                return;
            end
            v = with_state(3);
            if (m == ready_at)   v[B_WE]    = 1'b1;
            else if (m == TMO)   v[B_FAULT] = 1'b1;
            else                 v[B_WE]    = 1'b1;
            phase(v, $sformatf("%s_mem%0d", t, m), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'(m == ready_at), rs(rnd));
            if (m == ready_at) break;
        end
    endtask

    initial begin
        logic [7:0] jumps [4];
        logic [7:0] ir;
        logic [19:0] hv;
        jumps = '{8'h90, 8'h94, 8'h98, 8'h9C};
        bus.ip_clock_enable = 1'b1;
        bus.ip_IR           = 8'hF0;
        bus.ip_zero         = 1'b0;
        bus.ip_carry        = 1'b0;
        bus.ip_mem_ready    = 1'b0;
        @(posedge clock);
        #1;
        do_clear(2);

        for (int op = 0; op < 7; op++) begin
            run_instr(8'(op << 4) | ((op == 4) ? 8'h08 : 8'h00), 1'b0, 1'b1, 0, 0, 1'b0);
        end
        for (int j = 0; j < 4; j++) run_instr(jumps[j], 1'b1, 1'b0, 0, 0, 1'b0);

        run_instr(8'h70, 1'b0, 1'b0, 3, 0, 1'b0);
        run_instr(8'h70, 1'b1, 1'b1, 0, 0, 1'b0);
        run_instr(8'h48, 1'b0, 1'b0, 0, 5, 1'b0);
        run_instr(8'hC0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(8'hD4, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(8'h70, 1'b0, 1'b0, -1, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            ir = 8'($urandom);
            if (ir[7:4] == 4'hF) ir[7:4] = 4'hB;
            run_instr(ir, 1'($urandom), 1'($urandom), int'($urandom_range(0, TMO + 1)), 0, 1'b1);
        end

        run_instr(8'hF0 | 8'($urandom_range(0, 15)), 1'b0, 1'b0, 0, 0, 1'b0);
        hv = with_state(4);
        hv[B_HALT] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom), 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 hv, "halt");
        end
        do_clear(1);
        run_instr(8'h5C, 1'b1, 1'b1, 0, 0, 1'b0);

        repeat (2) @(posedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
